nibble_serial_adder: RTL and testbench

Multi-cycle wide-operand adder built around one 4-bit carry-lookahead slice. It accepts WIDTH-bit operands over a valid/ready handshake and feeds the slice one nibble per clock, least significant nibble first. A registered carry links each nibble to the next. The block returns the WIDTH-bit sum and carry-out over a second valid/ready handshake. It is the sequencing stage directly upstream of the 4-bit CLA slice, giving wide additions at the area of a single slice.

---
 rtl/nibble_serial_adder_pkg.sv | 17 +
 rtl/nibble_serial_adder_cla4_slice.sv | 27 ++
 rtl/nibble_serial_adder.sv | 136 +++++++++++++
 tb/tb_nibble_serial_adder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_adder_pkg.sv
// Shared constants and FSM state encoding for the nibble-serial adder.
package nibble_serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Nibble index width: ceil(log2(nibbles)), never narrower than one bit.
    function automatic int idx_width(input int nibbles);
        return (nibbles <= 1) ? 1 : $clog2(nibbles);
    endfunction

endpackage

// File: rtl/nibble_serial_adder_cla4_slice.sv
// Combinational 4-bit carry-lookahead slice; c3 (carry into bit 3) feeds overflow detection.
module cla4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout,
    output logic       c3
);

    logic [3:0] g;
    logic [3:0] p;
    logic       c1;
    logic       c2;

    assign g = a & b;
    assign p = a ^ b;

    assign c1   = g[0] | (p[0] & cin);
    assign c2   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c3   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign s = p ^ {c3, c2, c1, cin};

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder that walks one 4-bit CLA slice across the operands, LS nibble first.
// Optional SIGNED_OVF_EN adds a registered two's-complement overflow output (ovf).
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | waiting for operands, in_ready high
// RUN     | one nibble added per clock, idx selects nibble
// DONE    | result held, out_valid high until out_ready
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
`ifdef SIGNED_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = idx_width(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_width_check
        $error("WIDTH must be a positive multiple of 4");
    end

    state_t                state;
    logic [IDX_W-1:0]      idx;
    logic                  carry;
    logic [WIDTH-1:0]      op_a;
    logic [WIDTH-1:0]      op_b;
    logic [NIBBLE_W-1:0]   slice_a;
    logic [NIBBLE_W-1:0]   slice_b;
    logic [NIBBLE_W-1:0]   slice_s;
    logic                  slice_cout;

    always_comb begin
        slice_a = '0;
        slice_b = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx == IDX_W'(i)) begin
                slice_a = op_a[i*NIBBLE_W +: NIBBLE_W];
                slice_b = op_b[i*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

`ifdef SIGNED_OVF_EN
    logic slice_c3;
`else
    logic slice_c3_unused;
`endif

    cla4_slice u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry),
        .s    (slice_s),
        .cout (slice_cout),
`ifdef SIGNED_OVF_EN
        .c3   (slice_c3)
`else
        .c3   (slice_c3_unused)
`endif
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            idx   <= '0;
            carry <= 1'b0;
            op_a  <= '0;
            op_b  <= '0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef SIGNED_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_a  <= a;
                        op_b  <= b;
                        carry <= cin;
                        idx   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    for (int i = 0; i < NIBBLES; i++) begin
                        if (idx == IDX_W'(i)) begin
                            sum[i*NIBBLE_W +: NIBBLE_W] <= slice_s;
                        end
                    end
                    carry <= slice_cout;
                    if (idx == LAST_IDX) begin
                        cout  <= slice_cout;
`ifdef SIGNED_OVF_EN
                        ovf   <= slice_c3 ^ slice_cout;
`endif
                        // Park idx at zero so a single-nibble build never leaves it at 1.
                        idx   <= '0;
                        state <= ST_DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16): vector table plus scoreboard queue.
module tb_nibble_serial_adder;

    localparam int WIDTH   = 16;
    localparam int NIBBLES = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
`ifdef SIGNED_OVF_EN
    logic             ovf;
`endif

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
`ifdef SIGNED_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } exp_t;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        int               hold;
        logic [WIDTH-1:0] exp_sum;
        logic             exp_cout;
        logic             exp_ovf;
    } vec_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pop_compare(input string name);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: result with empty scoreboard, got sum 0x%0h", name, sum);
        end else begin
            e = exp_q.pop_front();
            check({name, "_valid"}, out_valid, 1);
            check({name, "_sum"}, sum, e.sum);
            check({name, "_cout"}, cout, e.cout);
`ifdef SIGNED_OVF_EN
            check({name, "_ovf"}, ovf, e.ovf);
`endif
        end
    endtask

    task automatic wait_result(input string name);
        int n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout, out_valid 0 expected 1", name);
        end else begin
            pop_compare(name);
        end
    endtask

    task automatic run_vec(input vec_t v, input int k);
        int    cyc;
        string nm;
        logic [WIDTH-1:0] held;
        nm = $sformatf("vec%0d", k);
        check({nm, "_pre_ready"}, in_ready, 1);
        exp_q.push_back('{v.exp_sum, v.exp_cout, v.exp_ovf});
        in_valid  = 1'b1;
        a         = v.a;
        b         = v.b;
        cin       = v.cin;
        out_ready = (v.hold == 0);
        @(negedge clk);
        in_valid = 1'b0;
        a        = WIDTH'($urandom);
        b        = WIDTH'($urandom);
        cin      = 1'($urandom);
        cyc      = 0;
        while (!out_valid && cyc < 20) begin
            check({nm, "_run_ready"}, in_ready, 0);
            check({nm, "_run_busy"}, busy, 1);
            @(negedge clk);
            cyc++;
        end
        check({nm, "_latency"}, cyc, NIBBLES);
        held = sum;
        for (int h = 0; h < v.hold; h++) begin
            check({nm, "_hold_valid"}, out_valid, 1);
            check({nm, "_hold_sum"}, sum, held);
            check({nm, "_hold_ready"}, in_ready, 0);
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            @(negedge clk);
        end
        out_ready = 1'b1;
        pop_compare(nm);
        @(negedge clk);
        check({nm, "_post_ready"}, in_ready, 1);
        check({nm, "_post_valid"}, out_valid, 0);
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 0, 16'h0100, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h1234, 16'h4321, 1'b0, 3, 16'h5555, 1'b0, 1'b0};
        vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 0, 16'h8000, 1'b0, 1'b1};
        vecs[4] = '{16'hFFFF, 16'h0001, 1'b0, 0, 16'h0000, 1'b1, 1'b0};
        vecs[5] = '{16'h8000, 16'h8000, 1'b0, 1, 16'h0000, 1'b1, 1'b1};
        vecs[6] = '{16'h0F0F, 16'h00F1, 1'b1, 0, 16'h1001, 1'b0, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 7; k++) begin
            run_vec(vecs[k], k);
        end

        // Reset in the middle of RUN (idx==2) discards the operation.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a         = 16'hABCD;
        b         = 16'h1111;
        cin       = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("midrst_busy_before", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_sum", sum, 0);
        check("midrst_cout", cout, 0);
        check("midrst_busy", busy, 0);
        begin
            int seen = 0;
            for (int i = 0; i < 10; i++) begin
                if (out_valid) seen++;
                @(negedge clk);
            end
            check("midrst_no_result", seen, 0);
        end

        // Back-to-back with in_valid held high.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a         = 16'h0003;
        b         = 16'h000C;
        cin       = 1'b0;
        exp_q.push_back('{16'h000F, 1'b0, 1'b0});
        @(negedge clk);
        a   = 16'h000A;
        b   = 16'h000D;
        cin = 1'b1;
        exp_q.push_back('{16'h0018, 1'b0, 1'b0});
        wait_result("b2b_first");
        check("b2b_done_ready", in_ready, 0);
        @(negedge clk);
        check("b2b_idle_ready", in_ready, 1);
        check("b2b_idle_valid", out_valid, 0);
        @(negedge clk);
        check("b2b_second_busy", busy, 1);
        in_valid = 1'b0;
        wait_result("b2b_second");
        @(negedge clk);
        check("b2b_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
